// File: rtl/mem_stage_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_bytelane
// Purpose  : MIPS memory stage built from four byte-lane BRAMs, with sub-word
//            loads and stores, the MEM/WB register, stall hold and PCSrc.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_bytelane #(
  parameter int ADDR_W = 9,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             Branch,
  input  logic             zero,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic             RegWriteEX,
  input  logic             MemtoRegEX,
  input  logic [31:0]      writeDataEX,
  input  logic [31:0]      ALUresultEX,
  input  logic [REG_W-1:0] writeRegEX,
  output logic             PCSrc,
  output logic             RegWriteMem,
  output logic             MemtoReg,
  output logic [31:0]      readData,
  output logic [31:0]      ALUresultMem,
  output logic [REG_W-1:0] writeRegMem,
  output logic             misalign
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [1:0] c_SZ_BYTE  = 2'b00;
  localparam logic [1:0] c_SZ_HALF  = 2'b01;

  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_idx;
  logic              w_mis;
  logic              w_access;
  logic              w_store;
  logic              w_ren;
  logic [3:0]        w_be;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       w_q;
  logic [31:0]       w_shift;
  logic [31:0]       w_rdata;

  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_sext;
  logic              r_ldv;

  assign w_off    = ALUresultEX[1:0];
  assign w_idx    = ALUresultEX[ADDR_W+1:2];
  assign w_mis    = ((size == c_SZ_HALF) && w_off[0]) || (size[1] && (w_off != 2'b00));
  assign w_access = MemRead | MemWrite;
  // Write enables are gated by rst_n so a store during reset never lands.
  assign w_store  = MemWrite & ~stall & ~w_mis & rst_n;
  assign w_ren    = MemRead & ~MemWrite & ~stall;
  assign w_we     = w_be & {4{w_store}};
  assign PCSrc    = Branch & zero;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeDataEX;
    case (size)
      c_SZ_BYTE: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{writeDataEX[7:0]}};
      end
      c_SZ_HALF: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writeDataEX[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;
    always_ff @(posedge clk) begin
      if (w_we[k]) r_mem[w_idx] <= w_wdata[8*k +: 8];
      if (w_ren)   r_q <= r_mem[w_idx];
    end
    assign w_q[8*k +: 8] = r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteMem  <= 1'b0;
      MemtoReg     <= 1'b0;
      ALUresultMem <= '0;
      writeRegMem  <= '0;
      misalign     <= 1'b0;
      r_ldv        <= 1'b0;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_sext       <= 1'b0;
    end else if (!stall) begin
      RegWriteMem  <= RegWriteEX & ~(w_access & w_mis);
      MemtoReg     <= MemtoRegEX;
      ALUresultMem <= ALUresultEX;
      writeRegMem  <= writeRegEX;
      misalign     <= w_access & w_mis;
      r_ldv        <= MemRead & ~MemWrite & ~w_mis;
      r_off        <= w_off;
      r_size       <= size;
      r_sext       <= sign_ext;
    end
  end

  assign w_shift = w_q >> {r_off, 3'b000};

  always_comb begin
    w_rdata = w_q;
    case (r_size)
      c_SZ_BYTE: w_rdata = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
      c_SZ_HALF: w_rdata = {{16{r_sext & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  assign readData = r_ldv ? w_rdata : 32'h0;

endmodule
`default_nettype wire
